// File: rtl/stopwatch_cmd_arbiter.sv
// rtl/stopwatch_cmd_arbiter.sv - round-robin command scheduler driving the stopwatch run/clear/lap controls
// Optional UART command source is built when STOPWATCH_UART_CMD_EN is defined.
module stopwatch_cmd_arbiter #(
    parameter int GUARD_CYCLES = 4,
    parameter int CLEAR_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_R,
    input  logic       btn_L,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       run_stop,
    output logic       clear,
    output logic       lap,
    output logic       drop,
    output logic       busy
);

    localparam int GW = (GUARD_CYCLES < 1) ? 1 : $clog2(GUARD_CYCLES + 1);
    localparam int CW = $clog2(CLEAR_CYCLES + 1);
    localparam logic OP_R = 1'b0;
    localparam logic OP_L = 1'b1;

    typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_CLEAR} state_t;

    state_t        state;
    logic [GW-1:0] guard;
    logic [CW-1:0] clr_cnt;
    logic          btn_v;
    logic          btn_op;
    logic          btn_wr;
    logic          btn_wop;
    logic          can_grant;
    logic          grant_btn;
    logic          grant_uart;
    logic          grant_any;
    logic          grant_op;
    logic          uart_wr;
    logic          uart_full_drop;

    assign btn_wr    = btn_R | btn_L;
    assign btn_wop   = btn_R ? OP_R : OP_L;
    assign can_grant = (state != ST_CLEAR) && (guard == '0);

`ifdef STOPWATCH_UART_CMD_EN
    localparam logic SRC_BTN  = 1'b0;
    localparam logic SRC_UART = 1'b1;

    logic uart_v;
    logic uart_op;
    logic uart_wop;
    logic rr_last;

    assign uart_wr    = rx_valid && ((rx_data == 8'h52) || (rx_data == 8'h4C));
    assign uart_wop   = (rx_data == 8'h4C) ? OP_L : OP_R;
    // With both slots pending, the source that did not win last time goes first.
    assign grant_btn  = can_grant && btn_v && (!uart_v || (rr_last == SRC_UART));
    assign grant_uart = can_grant && uart_v && (!btn_v || (rr_last == SRC_BTN));
    assign grant_op   = grant_btn ? btn_op : uart_op;
    assign uart_full_drop = uart_wr && uart_v && !grant_uart;
`else
    logic unused_rx;

    assign unused_rx  = ^{rx_data, rx_valid};
    assign uart_wr    = 1'b0;
    assign grant_btn  = can_grant && btn_v;
    assign grant_uart = 1'b0;
    assign grant_op   = btn_op;
    assign uart_full_drop = 1'b0;
`endif

    assign grant_any = grant_btn | grant_uart;
    assign busy      = (guard != '0) || (state == ST_CLEAR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_STOP;
            guard    <= '0;
            clr_cnt  <= '0;
            btn_v    <= 1'b0;
            btn_op   <= OP_R;
            run_stop <= 1'b0;
            clear    <= 1'b0;
            lap      <= 1'b0;
            drop     <= 1'b0;
`ifdef STOPWATCH_UART_CMD_EN
            uart_v   <= 1'b0;
            uart_op  <= OP_R;
            rr_last  <= SRC_UART;
`endif
        end else begin
            lap  <= 1'b0;
            drop <= (btn_R & btn_L) | (btn_wr & btn_v & ~grant_btn) | uart_full_drop;

            // A slot being granted this cycle frees up in time to accept a new write.
            if (btn_wr && (!btn_v || grant_btn)) begin
                btn_v  <= 1'b1;
                btn_op <= btn_wop;
            end else if (grant_btn) begin
                btn_v <= 1'b0;
            end

`ifdef STOPWATCH_UART_CMD_EN
            if (uart_wr && (!uart_v || grant_uart)) begin
                uart_v  <= 1'b1;
                uart_op <= uart_wop;
            end else if (grant_uart) begin
                uart_v <= 1'b0;
            end
            if (grant_any) begin
                rr_last <= grant_uart ? SRC_UART : SRC_BTN;
            end
`endif

            if (grant_any) begin
                guard <= GW'(GUARD_CYCLES);
            end else if (guard != '0) begin
                guard <= guard - GW'(1);
            end

            case (state)
                ST_CLEAR: begin
                    if (clr_cnt <= CW'(1)) begin
                        state   <= ST_STOP;
                        clear   <= 1'b0;
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt - CW'(1);
                    end
                end
                ST_STOP: begin
                    if (grant_any) begin
                        if (grant_op == OP_R) begin
                            state    <= ST_RUN;
                            run_stop <= 1'b1;
                        end else begin
                            state   <= ST_CLEAR;
                            clear   <= 1'b1;
                            clr_cnt <= CW'(CLEAR_CYCLES);
                        end
                    end
                end
                default: begin
                    if (grant_any) begin
                        if (grant_op == OP_R) begin
                            state    <= ST_STOP;
                            run_stop <= 1'b0;
                        end else begin
                            lap <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/stopwatch_cmd_arbiter.md
# stopwatch_cmd_arbiter

Command scheduler in front of the stopwatch datapath. It accepts run/stop and clear/lap requests from the debounced buttons and from the UART receive byte stream, and holds one pending command per source. A round-robin arbiter with a guard interval executes them through a STOP/RUN/CLEAR state machine. It drives the `run_stop`, `clear` and `lap` controls of the stopwatch counter.

## Interface
- `GUARD_CYCLES`, default 4: minimum quiet cycles after each executed command. Range 0..255.
- `CLEAR_CYCLES`, default 2: width of the `clear` pulse, in cycles. Must be ≥1.
- `clk`  in  1  system clock; all flops are on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `btn_R`  in  1  debounced single-cycle pulse: run/stop key.
- `btn_L`  in  1  debounced single-cycle pulse: clear/lap key.
- `rx_data`  in  8  UART received byte.
- `rx_valid`  in  1  single-cycle strobe; `rx_data` is valid in that cycle.
- `run_stop`  out  1  level; 1 while in RUN.
- `clear`  out  1  registered pulse, `CLEAR_CYCLES` wide.
- `lap`  out  1  registered 1-cycle pulse.
- `drop`  out  1  registered 1-cycle pulse; a request was discarded.
- `busy`  out  1  1 while the guard counter is nonzero or the state is CLEAR.

## Operation
- Reset (`rst`=0) takes effect immediately, including mid-CLEAR or mid-guard: state STOP, both slots empty, guard=0, rr_last=UART. All outputs are 0.
- Opcodes: KEY_R (run/stop), KEY_L (clear/lap).
- Button slot (valid bit + op bit):
  - `btn_R` writes KEY_R; `btn_L` writes KEY_L.
  - If both arrive in the same cycle, KEY_R is written, KEY_L is discarded and `drop` is pulsed.
- UART slot, decode on `rx_valid`:
  - 0x52 'R' → KEY_R; 0x4C 'L' → KEY_L.
  - Any other byte is ignored, with no write and no `drop`.
- Slot full: a write to an already-valid slot that is not being granted this cycle is discarded and `drop` is pulsed. The existing entry is kept.
- A write to a slot in the same cycle that slot is granted is accepted; the new entry is valid next cycle.
- Grant condition: state ≠ CLEAR, guard==0, and at least one slot valid.
  - If only one slot is valid, it is granted.
  - If both are valid, the source not equal to rr_last is granted.
  - On each grant, rr_last is updated to the granted source and the granted slot is cleared.
- Execution, on the grant edge:
  - STOP + KEY_R → RUN.
  - STOP + KEY_L → CLEAR.
  - RUN + KEY_R → STOP.
  - RUN + KEY_L → RUN, and `lap`=1 for one cycle.
- Every grant, including a no-effect one, loads guard with `GUARD_CYCLES`.
- Guard decrements by 1 per cycle while nonzero and saturates at 0.
- CLEAR state: `clear`=1 for exactly `CLEAR_CYCLES` cycles, then STOP. A down-counter of width $clog2(CLEAR_CYCLES+1) implements this. Slots keep filling during CLEAR, but nothing is granted.
- The guard counter width is $clog2(GUARD_CYCLES+1), with a minimum of 1 bit.

## Timing
- Request pulse in cycle t → slot valid in cycle t+1. If grantable, the grant executes at the end of t+1, and `run_stop`/`lap`/`clear` change in cycle t+2. Minimum latency is 2 cycles.
- `drop` is asserted in cycle t+1 for a request discarded in cycle t.
- Consecutive grants are at least `GUARD_CYCLES`+1 cycles apart. With `GUARD_CYCLES`=0, back-to-back grants are allowed.
- CLEAR entered at edge e: `clear`=1 for cycles e+1..e+`CLEAR_CYCLES`, and STOP holds from e+`CLEAR_CYCLES`+1.
- Earliest next grant after a CLEAR: in STOP with guard==0.
- `busy` is combinational from registered state and guard.

## Configuration
- `STOPWATCH_UART_CMD_EN` defined: the UART decode and UART slot are built, and round-robin applies as above.
- Not defined:
  - `rx_data`/`rx_valid` are present but ignored, and no UART slot logic is generated.
  - The button slot is the sole source, so rr_last is absent.
  - All button-side timing is unchanged.

## Test plan
- Reset release, `btn_R` pulse at cycle 10 → `run_stop`=1 from cycle 12, `busy`=1 for cycles 12..15.
- In RUN, `btn_L` at cycle 30 → `lap`=1 only in cycle 32, `run_stop` stays 1. Then `rx_data`=0x52 with `rx_valid` at cycle 31 → grant held off until guard reaches 0, `run_stop`=0 from cycle 37.
- In STOP, `rx_data`=0x4C with `rx_valid` → `clear`=1 for exactly 2 cycles, then STOP. A `btn_R` arriving during CLEAR is executed after CLEAR ends, once guard==0.
- `btn_R` and `rx_data`=0x52 both pending in the same cycle from reset → button granted first (RUN), UART granted 5 cycles later (STOP). rr_last then equals UART.
- `btn_R` and `btn_L` in the same cycle → `drop`=1 next cycle and only KEY_R is executed. A byte 0x41 with `rx_valid` → no state change, no `drop`.
- Assert `rst`=0 during the second cycle of `clear` → `clear`, `busy` and `run_stop` are 0 immediately. After release, state is STOP and both slots are empty.
